cubic_stream: RTL and testbench

Streaming, handshaked fixed-point cubic evaluator. It is the responder end of the test-vector stream that our cubic benches drive. It accepts (x, a0, a1, a2) tuples over a valid/ready input channel and evaluates y = x³ + a2·x² + a1·x + a0 in a 3-stage Horner pipeline. Each result is returned on a valid/ready output channel with full backpressure. It replaces free-running fixed-latency use of the cubic datapath wherever upstream or downstream logic can stall.

---
 rtl/cubic_pkg.sv | 21 ++
 rtl/cubic_horner_stage.sv | 39 +++
 rtl/cubic_stream.sv | 102 ++++++++++
 tb/tb_cubic_stream.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cubic_pkg.sv
// cubic_pkg: shared word/product types and fixed-point constants
// for the streaming cubic evaluator.
package cubic_pkg;

  localparam int CUBIC_WID   = 16;
  localparam int CUBIC_FBITS = 12;

  typedef logic signed [CUBIC_WID-1:0]   word_t;
  typedef logic signed [2*CUBIC_WID-1:0] prod_t;

  // (a*b) >>> FBITS, wrapped to one word; the shift floors toward -inf
  function automatic word_t fx_mul_trunc(
    input word_t a,
    input word_t b
  );
    prod_t p;
    p = prod_t'(a) * prod_t'(b);
    return word_t'(p >>> CUBIC_FBITS);
  endfunction

endpackage

// File: rtl/cubic_horner_stage.sv
// cubic_horner_stage: one registered Horner step out = (acc*x >>> FBITS) + c.
// Ports: clk, rst (async, active-low), en, in_v/acc/x/c in, out_v/out registered.
module cubic_horner_stage
  import cubic_pkg::*;
#(
  parameter int WID   = CUBIC_WID,
  parameter int FBITS = CUBIC_FBITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_v,
  input  logic signed [WID-1:0] acc,
  input  logic signed [WID-1:0] x,
  input  logic signed [WID-1:0] c,
  output logic                  out_v,
  output logic signed [WID-1:0] out
);

  logic signed [2*WID-1:0] prod;
  logic signed [WID-1:0]   sum;

  // full-width signed product, floor shift, then wrap to a word
  always_comb begin
    prod = (2*WID)'(acc) * (2*WID)'(x);
    sum  = WID'(prod >>> FBITS) + c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_v <= 1'b0;
      out   <= '0;
    end else if (en) begin
      out_v <= in_v;
      out   <= sum;
    end
  end

endmodule

// File: rtl/cubic_stream.sv
// cubic_stream: 3-stage handshaked Horner evaluator y = x^3 + a2*x^2 + a1*x + a0.
// Ports: in_valid/in_ready + x,a0,a1,a2 in; y_valid/y_ready + y out; busy.
module cubic_stream
  import cubic_pkg::*;
#(
  parameter int WID   = CUBIC_WID,
  parameter int FBITS = CUBIC_FBITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [WID-1:0] x,
  input  logic signed [WID-1:0] a0,
  input  logic signed [WID-1:0] a1,
  input  logic signed [WID-1:0] a2,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic signed [WID-1:0] y,
  output logic                  busy
);

  logic en;

  logic                  v1;
  logic signed [WID-1:0] x1;
  logic signed [WID-1:0] a0_1;
  logic signed [WID-1:0] a1_1;
  logic signed [WID-1:0] t1;

  logic                  v2;
  logic signed [WID-1:0] x2;
  logic signed [WID-1:0] a0_2;
  logic signed [WID-1:0] t2;

  // whole pipe moves together; only a held result stops it,
  // so bubbles are never collapsed
  assign en       = !y_valid || y_ready;
  assign in_ready = en;
  assign busy     = v1 | v2 | y_valid;

  // stage 1: first Horner term x + a2 and operand capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1   <= 1'b0;
      x1   <= '0;
      a0_1 <= '0;
      a1_1 <= '0;
      t1   <= '0;
    end else if (en) begin
      v1   <= in_valid;
      x1   <= x;
      a0_1 <= a0;
      a1_1 <= a1;
      t1   <= x + a2;
    end
  end

  // stage 2: t2 = t1*x + a1
  cubic_horner_stage #(
    .WID   (WID),
    .FBITS (FBITS)
  ) u_s2 (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .in_v  (v1),
    .acc   (t1),
    .x     (x1),
    .c     (a1_1),
    .out_v (v2),
    .out   (t2)
  );

  // operands still needed by stage 3
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x2   <= '0;
      a0_2 <= '0;
    end else if (en) begin
      x2   <= x1;
      a0_2 <= a0_1;
    end
  end

  // stage 3: y = t2*x + a0, held while downstream stalls
  cubic_horner_stage #(
    .WID   (WID),
    .FBITS (FBITS)
  ) u_s3 (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .in_v  (v2),
    .acc   (t2),
    .x     (x2),
    .c     (a0_2),
    .out_v (y_valid),
    .out   (y)
  );

endmodule

// File: tb/tb_cubic_stream.sv
// tb_cubic_stream: directed self-checking bench for cubic_stream
// (single tuples, backpressure, reset mid-stream, streaming).
module tb_cubic_stream;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic y_ready = 1'b0;
  logic in_ready;
  logic y_valid;
  logic busy;
  logic signed [15:0] x = '0;
  logic signed [15:0] a0 = '0;
  logic signed [15:0] a1 = '0;
  logic signed [15:0] a2 = '0;
  logic signed [15:0] y;

  int n_run = 0;
  int n_fail = 0;
  int in_idx;
  int out_idx;
  logic take;
  logic give;

  always #5 clk = ~clk;

  cubic_stream dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .a0       (a0),
    .a1       (a1),
    .a2       (a2),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .y        (y),
    .busy     (busy)
  );

  task automatic chk(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    n_run++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(
    input logic signed [15:0] xi,
    input logic signed [15:0] c0,
    input logic signed [15:0] c1,
    input logic signed [15:0] c2
  );
    x  = xi;
    a0 = c0;
    a1 = c1;
    a2 = c2;
  endtask

  // one tuple through an empty pipe with y_ready high
  task automatic run_one(
    input string             tag,
    input logic signed [15:0] xi,
    input logic signed [15:0] c0,
    input logic signed [15:0] c1,
    input logic signed [15:0] c2,
    input logic [15:0]       exp
  );
    y_ready = 1'b1;
    put(xi, c0, c1, c2);
    in_valid = 1'b1;
    #1;
    chk({tag, "/in_ready"}, 16'(in_ready), 16'd1);
    step();
    in_valid = 1'b0;
    chk({tag, "/vld_e0"}, 16'(y_valid), 16'd0);
    step();
    chk({tag, "/vld_e1"}, 16'(y_valid), 16'd0);
    step();
    chk({tag, "/vld_e2"}, 16'(y_valid), 16'd1);
    chk({tag, "/y"}, y, exp);
    step();
    chk({tag, "/drained"}, 16'(y_valid), 16'd0);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst/y_valid", 16'(y_valid), 16'd0);
    chk("rst/y", y, 16'd0);
    chk("rst/busy", 16'(busy), 16'd0);
    chk("rst/in_ready", 16'(in_ready), 16'd1);
    step();
    rst = 1'b1;
    step();

    // single-tuple directed vectors
    run_one("ident", 16'sd4096, 0, 0, 0, 16'd4096);
    run_one("mixed", 16'sd8192, 0, 0, -16'sd4096, 16'd16384);
    run_one("const", 0, 16'sd1234, 0, 0, 16'd1234);
    run_one("neg1", -16'sd1, 0, 0, 0, 16'd0);
    run_one("wrap64", 16'sd16384, 0, 0, 0, 16'd0);
    run_one("minus1", -16'sd4096, 0, 0, 0, 16'hF000);
    run_one("frac", 16'sd6144, 16'sd2048, -16'sd8192,
            16'sd4096, 16'd12800);
    run_one("floor", 16'sd3, 0, 0, -16'sd4096, 16'hFFFF);
    run_one("addwrap", 16'sd4096, 16'sd32767, 0, 0, 16'h8FFF);

    // backpressure: fill three stages, then stall
    y_ready = 1'b0;
    put(16'sd4096, 0, 0, 0);
    in_valid = 1'b1;
    #1;
    chk("bp/rdy0", 16'(in_ready), 16'd1);
    step();
    put(16'sd4096, 16'sd1000, 0, 0);
    #1;
    chk("bp/rdy1", 16'(in_ready), 16'd1);
    step();
    put(16'sd4096, 16'sd2000, 0, 0);
    #1;
    chk("bp/rdy2", 16'(in_ready), 16'd1);
    step();
    put(16'sd4096, 16'sd3000, 0, 0);
    #1;
    chk("bp/full_rdy", 16'(in_ready), 16'd0);
    chk("bp/full_vld", 16'(y_valid), 16'd1);
    chk("bp/full_y", y, 16'd4096);
    step();
    step();
    chk("bp/hold_y", y, 16'd4096);
    chk("bp/hold_vld", 16'(y_valid), 16'd1);
    chk("bp/hold_rdy", 16'(in_ready), 16'd0);
    chk("bp/hold_busy", 16'(busy), 16'd1);

    // drain with input still offered: results 4096 + 1000*k in order
    y_ready = 1'b1;
    in_idx = 3;
    out_idx = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      take = in_valid && in_ready;
      give = y_valid && y_ready;
      if (give) begin
        chk($sformatf("bp/y%0d", out_idx), y, 16'(4096 + 1000 * out_idx));
        out_idx++;
      end
      step();
      if (take) begin
        in_idx++;
        if (in_idx < 5) put(16'sd4096, 16'(1000 * in_idx), 0, 0);
        else in_valid = 1'b0;
      end
    end
    chk("bp/count", 16'(out_idx), 16'd5);
    chk("bp/empty_vld", 16'(y_valid), 16'd0);
    chk("bp/empty_busy", 16'(busy), 16'd0);

    // reset with three tuples in flight and y stalled
    y_ready = 1'b0;
    put(16'sd4096, 16'sd111, 0, 0);
    in_valid = 1'b1;
    step();
    put(16'sd4096, 16'sd222, 0, 0);
    step();
    put(16'sd4096, 16'sd333, 0, 0);
    step();
    chk("mrst/pre_vld", 16'(y_valid), 16'd1);
    chk("mrst/pre_y", y, 16'd4207);
    #2;
    rst = 1'b0;
    #1;
    chk("mrst/vld", 16'(y_valid), 16'd0);
    chk("mrst/busy", 16'(busy), 16'd0);
    chk("mrst/y", y, 16'd0);
    chk("mrst/in_ready", 16'(in_ready), 16'd1);
    step();
    step();
    chk("mrst/held_busy", 16'(busy), 16'd0);
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    chk("mrst/post_busy", 16'(busy), 16'd0);
    chk("mrst/post_vld", 16'(y_valid), 16'd0);
    run_one("mrst/new", 16'sd6144, 16'sd2048, -16'sd8192,
            16'sd4096, 16'd12800);

    // 100 back-to-back tuples, y = 4096 + 100*i
    y_ready = 1'b1;
    put(16'sd4096, 0, 0, 0);
    in_valid = 1'b1;
    #1;
    chk("strm/in_ready", 16'(in_ready), 16'd1);
    for (int c = 0; c <= 102; c++) begin
      step();
      if (c + 1 < 100) put(16'sd4096, 16'(100 * (c + 1)), 0, 0);
      else in_valid = 1'b0;
      if (c >= 2 && c <= 101) begin
        chk($sformatf("strm/vld%0d", c), 16'(y_valid), 16'd1);
        chk($sformatf("strm/y%0d", c), y, 16'(4096 + 100 * (c - 2)));
      end else begin
        chk($sformatf("strm/idle%0d", c), 16'(y_valid), 16'd0);
      end
    end
    chk("strm/end_busy", 16'(busy), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
